spi_ram_ctrl: RTL and testbench

//   Command decoder and synchronous RAM downstream of the SPI slave. It consumes each 10-bit rx word:
//   - rx_data[9:8] is the command.
//   - rx_data[7:0] is the address or data payload.

---
 rtl/spi_ram_pkg.sv | 23 ++
 rtl/spi_ram_mem.sv | 24 ++
 rtl/spi_ram_ctrl.sv | 113 +++++++++++
 tb/tb_spi_ram_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI RAM controller: command codes, one-hot FSM states, word widths.
// SPI_RAM_PARITY_EN widens stored words by one parity bit.
package spi_ram_pkg;
   localparam int RX_W   = 10;
   localparam int DATA_W = 8;
`ifdef SPI_RAM_PARITY_EN
   localparam int MEM_W  = DATA_W + 1;
`else
   localparam int MEM_W  = DATA_W;
`endif

   typedef enum logic [1:0] {
      CMD_SET_WR_ADDR = 2'b00,
      CMD_WR_DATA     = 2'b01,
      CMD_SET_RD_ADDR = 2'b10,
      CMD_RD_DATA     = 2'b11
   } cmd_e;

   localparam int         ST_W     = 3;
   localparam logic [2:0] IDLE     = 3'b001;
   localparam logic [2:0] RD_FETCH = 3'b010;
   localparam logic [2:0] RD_HOLD  = 3'b100;
endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, registered read port (data one edge after i_re), no reset of contents.
// Word width is MEM_W (9 bits when SPI_RAM_PARITY_EN is defined).
module spi_ram_mem
   import spi_ram_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [AW-1:0]    i_addr,
   input  logic [MEM_W-1:0] i_wdata,
   output logic [MEM_W-1:0] o_rdata
);
   logic [MEM_W-1:0] r_mem [2**AW];
   logic [MEM_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata       <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder + RAM behind the SPI slave; read data valid two edges after RD_DATA, busy in RD_FETCH.
// SPI_RAM_PARITY_EN adds a stored parity bit and the o_spi_ram_parity_err pulse.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = 8,
   parameter bit AUTO_INC   = 1'b1
) (
   input  logic              i_spi_ram_clk,
   input  logic              i_spi_ram_rst_n,
   input  logic [RX_W-1:0]   i_spi_ram_rx_data,
   input  logic              i_spi_ram_rx_valid,
   output logic [DATA_W-1:0] o_spi_ram_tx_data,
   output logic              o_spi_ram_tx_valid,
   output logic              o_spi_ram_busy,
   output logic              o_spi_ram_addr_err,
   output logic              o_spi_ram_parity_err
);
   logic [ST_W-1:0]       r_state, w_next_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, w_mem_addr;
   logic [DATA_W-1:0]     r_tx_data;
   logic                  r_addr_err;
   logic                  w_accept, w_mem_we, w_mem_re, w_d_oor;
   cmd_e                  w_cmd;
   logic [DATA_W-1:0]     w_d;
   logic [MEM_W-1:0]      w_wdata, w_rdata;

   function automatic logic [ADDR_WIDTH-1:0] f_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_cmd    = cmd_e'(i_spi_ram_rx_data[9:8]);
   assign w_d      = i_spi_ram_rx_data[7:0];
   assign w_d_oor  = ({1'b0, w_d} >= 9'(MEM_DEPTH));
   assign w_accept = i_spi_ram_rx_valid && (r_state != RD_FETCH);

   always_ff @(posedge i_spi_ram_clk or negedge i_spi_ram_rst_n) begin
      if (!i_spi_ram_rst_n) r_state <= IDLE;
      else                  r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, RD_HOLD: if (w_accept) w_next_state = (w_cmd == CMD_RD_DATA) ? RD_FETCH : IDLE;
         RD_FETCH:      w_next_state = RD_HOLD;
         default:       w_next_state = IDLE;
      endcase
   end

   always_comb begin
      o_spi_ram_busy     = (r_state == RD_FETCH);
      o_spi_ram_tx_valid = (r_state == RD_HOLD);
      w_mem_we           = w_accept && (w_cmd == CMD_WR_DATA);
      w_mem_re           = w_accept && (w_cmd == CMD_RD_DATA);
      w_mem_addr         = w_mem_we ? r_wr_ptr : r_rd_ptr;
   end

   // Out-of-range SET_* flags the error but still keeps the truncated pointer.
   always_ff @(posedge i_spi_ram_clk or negedge i_spi_ram_rst_n) begin
      if (!i_spi_ram_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_tx_data  <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_accept && w_d_oor &&
                       ((w_cmd == CMD_SET_WR_ADDR) || (w_cmd == CMD_SET_RD_ADDR));
         if (w_accept) begin
            case (w_cmd)
               CMD_SET_WR_ADDR: r_wr_ptr <= w_d[ADDR_WIDTH-1:0];
               CMD_WR_DATA:     if (AUTO_INC) r_wr_ptr <= f_inc(r_wr_ptr);
               CMD_SET_RD_ADDR: r_rd_ptr <= w_d[ADDR_WIDTH-1:0];
               default:         ;
            endcase
         end
         if (r_state == RD_FETCH) begin
            r_tx_data <= w_rdata[DATA_W-1:0];
            if (AUTO_INC) r_rd_ptr <= f_inc(r_rd_ptr);
         end
      end
   end

`ifdef SPI_RAM_PARITY_EN
   logic r_parity_err;
   assign w_wdata = {^w_d, w_d};
   always_ff @(posedge i_spi_ram_clk or negedge i_spi_ram_rst_n) begin
      if (!i_spi_ram_rst_n) r_parity_err <= 1'b0;
      else r_parity_err <= (r_state == RD_FETCH) && (w_rdata[DATA_W] != ^w_rdata[DATA_W-1:0]);
   end
   assign o_spi_ram_parity_err = r_parity_err;
`else
   assign w_wdata              = w_d;
   assign o_spi_ram_parity_err = 1'b0;
`endif

   assign o_spi_ram_tx_data  = r_tx_data;
   assign o_spi_ram_addr_err = r_addr_err;

   spi_ram_mem #(.AW(ADDR_WIDTH)) u_mem (
      .i_clk   (i_spi_ram_clk),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_addr  (w_mem_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

   // The slave's framing guarantees no word arrives during the fetch cycle.
   a_no_rx_while_busy: assert property (@(posedge i_spi_ram_clk) disable iff (!i_spi_ram_rst_n)
      !(i_spi_ram_rx_valid && o_spi_ram_busy));
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: a 256-deep and a 16-deep instance share stimulus and are compared each cycle
// against a command-level model; directed sequences add literal checks (parity case under SPI_RAM_PARITY_EN).
module tb_spi_ram_ctrl;
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [9:0]      rx_data = '0;
   logic            rx_valid = 1'b0;
   logic [1:0][7:0] tx_data;
   logic [1:0]      tx_valid, busy, aerr, perr;

   int errs = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   int         depth [2] = '{256, 16};
   logic [7:0] m_mem [2][256];
   bit         m_pbad [2][256];
   int         m_wp [2], m_rp [2];
   logic [7:0] m_fetch [2];
   bit         m_fetch_bad [2];
   logic       e_busy [2], e_txv [2], e_aerr [2], e_perr [2];
   logic [7:0] e_txd [2];

   always #5 clk = ~clk;

   spi_ram_ctrl dut (
      .i_spi_ram_clk(clk), .i_spi_ram_rst_n(rst_n),
      .i_spi_ram_rx_data(rx_data), .i_spi_ram_rx_valid(rx_valid),
      .o_spi_ram_tx_data(tx_data[0]), .o_spi_ram_tx_valid(tx_valid[0]),
      .o_spi_ram_busy(busy[0]), .o_spi_ram_addr_err(aerr[0]),
      .o_spi_ram_parity_err(perr[0])
   );

   spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_WIDTH(4), .AUTO_INC(1'b1)) dut16 (
      .i_spi_ram_clk(clk), .i_spi_ram_rst_n(rst_n),
      .i_spi_ram_rx_data(rx_data), .i_spi_ram_rx_valid(rx_valid),
      .o_spi_ram_tx_data(tx_data[1]), .o_spi_ram_tx_valid(tx_valid[1]),
      .o_spi_ram_busy(busy[1]), .o_spi_ram_addr_err(aerr[1]),
      .o_spi_ram_parity_err(perr[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_wp[k] = 0; m_rp[k] = 0;
         e_busy[k] = 1'b0; e_txv[k] = 1'b0; e_aerr[k] = 1'b0; e_perr[k] = 1'b0;
         e_txd[k] = 8'h00;
      end
   endtask

   // Effect of one clock edge with the given input word, at command level.
   task automatic model_step(input bit v, input logic [9:0] w);
      int d;
      d = int'(w[7:0]);
      for (int k = 0; k < 2; k++) begin
         e_aerr[k] = 1'b0;
         e_perr[k] = 1'b0;
         if (e_busy[k]) begin
            e_txd[k]  = m_fetch[k];
            e_txv[k]  = 1'b1;
            e_busy[k] = 1'b0;
            e_perr[k] = m_fetch_bad[k];
            m_rp[k]   = (m_rp[k] + 1) % depth[k];
         end else if (v) begin
            e_txv[k] = 1'b0;
            case (w[9:8])
               2'b00: begin m_wp[k] = d % depth[k]; e_aerr[k] = (d >= depth[k]); end
               2'b01: begin
                  m_mem[k][m_wp[k]]  = w[7:0];
                  m_pbad[k][m_wp[k]] = 1'b0;
                  m_wp[k] = (m_wp[k] + 1) % depth[k];
               end
               2'b10: begin m_rp[k] = d % depth[k]; e_aerr[k] = (d >= depth[k]); end
               default: begin
                  m_fetch[k]     = m_mem[k][m_rp[k]];
                  m_fetch_bad[k] = m_pbad[k][m_rp[k]];
                  e_busy[k]      = 1'b1;
               end
            endcase
         end
      end
   endtask

   // Drive one word (or idle) for a single edge; returns #1 after that edge.
   task automatic step(input bit v, input logic [9:0] w);
      rx_valid = v;
      rx_data  = w;
      @(posedge clk);
      #1;
      model_step(v, w);
      rx_valid = 1'b0;
   endtask

   task automatic cmd(input logic [9:0] w);
      step(1'b1, w);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy[%0d]", k),     busy[k],     e_busy[k]);
            chk($sformatf("tx_valid[%0d]", k), tx_valid[k], e_txv[k]);
            chk($sformatf("tx_data[%0d]", k),  tx_data[k],  e_txd[k]);
            chk($sformatf("addr_err[%0d]", k), aerr[k],     e_aerr[k]);
            chk($sformatf("parity_err[%0d]", k), perr[k],   e_perr[k]);
         end
      end
   end

   initial begin
      logic [9:0] w;
      bit v;
      model_reset();
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 256; a++) begin m_mem[k][a] = 8'h00; m_pbad[k][a] = 1'b0; end

      // T1 reset
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_tx_valid", tx_valid, 2'b00);
      chk("rst_busy", busy, 2'b00);
      chk("rst_tx_data", tx_data, 16'h0000);
      chk("rst_errs", {aerr, perr}, 4'b0000);
      chk_en = 1'b1;

      // Fill every location so random reads never hit uninitialised RAM
      cmd(10'h000);
      for (int a = 0; a < 256; a++) cmd({2'b01, 8'($urandom_range(0, 255))});

      // T2 write/readback
      cmd(10'h005); cmd(10'h1A5); cmd(10'h205); cmd(10'h300);
      chk("t2_busy", busy[0], 1'b1);
      step(1'b0, 10'h000);
      chk("t2_tx_valid", tx_valid[0], 1'b1);
      chk("t2_tx_data", tx_data[0], 8'hA5);
      chk("t2_tx_data16", tx_data[1], 8'hA5);

      // T3 auto-increment with wrap (256 wraps at 0xFF, 16-deep wraps at 0xF)
      cmd(10'h0FE); cmd(10'h111); cmd(10'h122); cmd(10'h133); cmd(10'h2FE);
      cmd(10'h300); step(1'b0, 10'h000); chk("t3_rd0", tx_data[0], 8'h11);
      cmd(10'h300); step(1'b0, 10'h000); chk("t3_rd1", tx_data[0], 8'h22);
      cmd(10'h300); step(1'b0, 10'h000); chk("t3_rd2_wrap", tx_data[0], 8'h33);
      chk("t3_rd2_wrap16", tx_data[1], 8'h33);

      // T4 range error on the 16-deep instance
      cmd(10'h014);
      chk("t4_aerr16", aerr[1], 1'b1);
      chk("t4_aerr256", aerr[0], 1'b0);
      step(1'b0, 10'h000);
      chk("t4_aerr16_pulse", aerr[1], 1'b0);
      cmd(10'h1C7); cmd(10'h204); cmd(10'h300); step(1'b0, 10'h000);
      chk("t4_trunc_write", tx_data[1], 8'hC7);

      // T5 write to the held location leaves tx_data alone
      cmd(10'h040); cmd(10'h15A); cmd(10'h240); cmd(10'h300); step(1'b0, 10'h000);
      chk("t5_held", tx_data[0], 8'h5A);
      cmd(10'h040); cmd(10'h1C3);
      chk("t5_held_after_wr", tx_data[0], 8'h5A);
      chk("t5_valid_dropped", tx_valid[0], 1'b0);
      cmd(10'h240); cmd(10'h300); step(1'b0, 10'h000);
      chk("t5_new_value", tx_data[0], 8'hC3);

      // T5 reset while holding, then while fetching
      chk_en = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("t5_rst_hold_valid", tx_valid[0], 1'b0);
      #1 rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      cmd(10'h300);
      chk_en = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("t5_rst_fetch_busy", busy, 2'b00);
      chk("t5_rst_fetch_valid", tx_valid, 2'b00);
      #1 rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      step(1'b0, 10'h000);
      chk("t5_after_rst_valid", tx_valid[0], 1'b0);

`ifdef SPI_RAM_PARITY_EN
      // T6 corrupted parity bit at addr 3 of the 256-deep instance
      dut.u_mem.r_mem[3][8] = ~dut.u_mem.r_mem[3][8];
      m_pbad[0][3] = 1'b1;
      cmd(10'h203); cmd(10'h300); step(1'b0, 10'h000);
      chk("t6_parity_err", perr[0], 1'b1);
      chk("t6_parity_ok16", perr[1], 1'b0);
      step(1'b0, 10'h000);
      chk("t6_parity_pulse", perr[0], 1'b0);
`else
      cmd(10'h203); cmd(10'h300); step(1'b0, 10'h000);
      chk("t6_parity_tied", perr[0], 1'b0);
`endif

      // Random command stream; reads are weighted up, nothing is offered while busy
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 9) < 7) && !e_busy[0];
         w = 10'($urandom);
         if ($urandom_range(0, 3) == 0) w[9:8] = 2'b11;
         step(v, w);
      end

      step(1'b0, 10'h000);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
